// File: rtl/regfile_2r1w.sv
// 2^DEPTH_LOG2 x WIDTH register file: two combinational reads, one synchronous write, r0 reads 0.
// Optional same-cycle write-to-read bypass (BYPASS=1).
module regfile_2r1w #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 5,
   parameter int BYPASS     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DEPTH_LOG2-1:0] read_addr1,
   input  logic [DEPTH_LOG2-1:0] read_addr2,
   output logic [WIDTH-1:0]      read_data1,
   output logic [WIDTH-1:0]      read_data2,
   input  logic                  write_en,
   input  logic [DEPTH_LOG2-1:0] write_addr,
   input  logic [WIDTH-1:0]      write_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0] r_mem  [1:DEPTH-1];
   logic [WIDTH-1:0] w_regs [0:DEPTH-1];
   logic [DEPTH-1:0] w_wr_dec;
   logic             w_byp1;
   logic             w_byp2;

   // Bit 0 forced low: discards r0 writes and keeps address 0 out of the bypass.
   always_comb begin
      w_wr_dec = '0;
      if (write_en) begin
         w_wr_dec[write_addr] = 1'b1;
      end
      w_wr_dec[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (w_wr_dec[i]) begin
               r_mem[i] <= write_data;
            end
         end
      end
   end

   assign w_regs[0] = '0;
   for (genvar g = 1; g < DEPTH; g++) begin : g_regs
      assign w_regs[g] = r_mem[g];
   end

   assign w_byp1 = (BYPASS != 0) && w_wr_dec[read_addr1];
   assign w_byp2 = (BYPASS != 0) && w_wr_dec[read_addr2];

   assign read_data1 = w_byp1 ? write_data : w_regs[read_addr1];
   assign read_data2 = w_byp2 ? write_data : w_regs[read_addr2];

endmodule
